// File: rtl/seq_subtractor_12bit.sv
// Multi-cycle unsigned subtractor: diff = (ain - bin) mod 2^WIDTH.
// Works through STEP bits per BUSY cycle, LSB-first, and ripples the borrow
// from each slice into the next. Valid/ready handshake on input and output.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand handshake; in_ready is high only in IDLE
//   ain, bin        minuend / subtrahend, unsigned
//   out_valid/ready result handshake; out_valid is high only in DONE
//   diff            (ain - bin) mod 2^WIDTH
//   borrow          1 iff ain < bin
//   zero            1 iff diff == 0
module seq_subtractor_12bit #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned STEP  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned NSTEP = WIDTH / STEP;
  localparam int unsigned StepW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(NSTEP - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;

  logic [STEP-1:0]    a_sl, b_sl;
  logic [STEP:0]      sl_res;
  logic [WIDTH-1:0]   diff_slc;

  // Slice arithmetic for the current step index.
  always_comb begin
    a_sl     = a_q[step_q*STEP +: STEP];
    b_sl     = b_q[step_q*STEP +: STEP];
    // Extra top bit catches the borrow out of this slice.
    sl_res   = {1'b0, a_sl} - {1'b0, b_sl} - {{STEP{1'b0}}, br_q};
    diff_slc = diff_q;
    diff_slc[step_q*STEP +: STEP] = sl_res[STEP-1:0];
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = ain;
          b_d     = bin;
          br_d    = 1'b0;
          step_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        diff_d = diff_slc;
        br_d   = sl_res[STEP];
        step_d = step_q + 1'b1;
        if (step_q == LastStep) begin
          // Zero test uses the merged vector so the final slice counts.
          borrow_d = sl_res[STEP];
          zero_d   = (diff_slc == '0);
          step_d   = '0;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  // Handshake outputs decode the state register only.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

endmodule
